// File: rtl/alu_cmd_issuer.sv
// Command FIFO -> credit-gated ALU issue -> fixed-latency capture -> result FIFO.
// Credits cover result slots plus in-flight ops, so the non-stallable ALU never overflows the result FIFO.
module alu_cmd_issuer #(
  parameter int DATA_W    = 8,
  parameter int OP_W      = 3,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_c,
  output logic              busy
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int CCW = CAW + 1;
  localparam int RAW = $clog2(RES_DEPTH);
  localparam int RCW = RAW + 1;
  localparam logic [CCW-1:0] CMD_FULL = CCW'(CMD_DEPTH);
  localparam logic [RCW-1:0] RES_FULL = RCW'(RES_DEPTH);
  localparam logic [RCW:0]   RES_CAP  = (RCW+1)'(RES_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;

  typedef struct packed {
    logic              c;
    logic [DATA_W-1:0] data;
  } res_t;

  // ---------------- command FIFO ----------------
  cmd_t           cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr, cmd_rd;
  logic [CCW-1:0] cmd_count;
  logic           ready_en;
  logic           cmd_push;
  logic           issue;
  cmd_t           cmd_in, cmd_head;

  // ---------------- issue / in-flight ----------------
  logic [RCW-1:0] inflight;
  logic [RCW:0]   res_used;
  logic [ALU_LAT:0] vld_pipe;
  logic           capture;

  // ---------------- result FIFO ----------------
  res_t           res_mem [RES_DEPTH];
  logic [RAW-1:0] res_wr, res_rd;
  logic [RCW-1:0] res_count;
  logic           res_pop;
  res_t           res_in, res_head;

  assign cmd_in   = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign cmd_head = cmd_mem[cmd_rd];

  // ready_en keeps cmd_ready low through reset and the release cycle
  assign cmd_ready = ready_en && (cmd_count < CMD_FULL);
  assign cmd_push  = cmd_valid && cmd_ready;

  assign res_used = {1'b0, res_count} + {1'b0, inflight};
  assign issue    = (cmd_count != '0) && (res_used < RES_CAP);
  assign capture  = vld_pipe[ALU_LAT];

  assign res_in    = '{c: alu_c, data: alu_out};
  assign res_head  = res_mem[res_rd];
  assign res_valid = (res_count != '0);
  assign res_pop   = res_valid && res_ready;
  assign res_data  = res_valid ? res_head.data : '0;
  assign res_c     = res_valid ? res_head.c    : 1'b0;

  assign busy = (cmd_count != '0) || (inflight != '0) || (res_count != '0);

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en  <= 1'b0;
      cmd_wr    <= '0;
      cmd_rd    <= '0;
      cmd_count <= '0;
    end else begin
      ready_en <= 1'b1;
      if (cmd_push) cmd_wr <= cmd_wr + 1'b1;
      if (issue)    cmd_rd <= cmd_rd + 1'b1;
      cmd_count <= cmd_count + CCW'(cmd_push) - CCW'(issue);
    end
  end

  // ALU operand registers hold their value when nothing issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      vld_pipe <= '0;
      inflight <= '0;
    end else begin
      if (issue) begin
        alu_a  <= cmd_head.a;
        alu_b  <= cmd_head.b;
        alu_op <= cmd_head.op;
      end
      vld_pipe[0] <= issue;
      for (int i = 1; i <= ALU_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      inflight <= inflight + RCW'(issue) - RCW'(capture);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) res_mem[res_wr] <= res_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_wr    <= '0;
      res_rd    <= '0;
      res_count <= '0;
    end else begin
      if (capture) res_wr <= res_wr + 1'b1;
      if (res_pop) res_rd <= res_rd + 1'b1;
      res_count <= res_count + RCW'(capture) - RCW'(res_pop);
    end
  end

  // Credit accounting must make a capture into a full result FIFO impossible
  always_ff @(posedge clk) begin
    if (!rst && capture) assert (res_count < RES_FULL);
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a one-stage adder ALU stub (out=a+b, c=carry).
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic       alu_c;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_c;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int sent = 0;
  int got  = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DATA_W(8), .OP_W(3), .CMD_DEPTH(4), .RES_DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_c(res_c), .busy(busy)
  );

  // ALU stub, one register stage
  logic [8:0] alu_sum = '0;
  always @(posedge clk) alu_sum <= {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out = alu_sum[7:0];
  assign alu_c   = alu_sum[8];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp_d;
    logic       exp_c;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One isolated command; called and returns at a falling edge
  task automatic run_single(input vec_t v, input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_op = v.op;
    @(negedge clk);                        // E0 handshake done
    cmd_valid = 1'b0;
    @(negedge clk);                        // after E1
    chk({tag, "_alu_a"}, alu_a, v.a);
    chk({tag, "_alu_b"}, alu_b, v.b);
    chk({tag, "_alu_op"}, alu_op, v.op);
    @(negedge clk);                        // after E2
    chk({tag, "_early_valid"}, res_valid, 0);
    chk({tag, "_busy"}, busy, 1);
    @(negedge clk);                        // after E3
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_res_data"}, res_data, v.exp_d);
    chk({tag, "_res_c"}, res_c, v.exp_c);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_drained"}, res_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // One cycle of a streaming source (a=k, b=0) and sink checking in-order results
  task automatic step(input int n, input logic rr);
    logic fire, pop;
    cmd_valid = (sent < n);
    cmd_a     = 8'(sent + 1);
    cmd_b     = 8'h00;
    cmd_op    = 3'(sent);
    res_ready = rr;
    fire = cmd_valid && cmd_ready;
    pop  = res_valid && res_ready;
    if (pop) begin
      chk("order_data", res_data, 8'(got + 1));
      chk("order_c", res_c, 0);
    end
    @(negedge clk);
    if (fire) sent++;
    if (pop)  got++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_v, vcnt;
    vecs[0] = '{a: 8'h0F, b: 8'h01, op: 3'd0, exp_d: 8'h10, exp_c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, op: 3'd1, exp_d: 8'h00, exp_c: 1'b1};
    vecs[2] = '{a: 8'h80, b: 8'h80, op: 3'd2, exp_d: 8'h00, exp_c: 1'b1};
    vecs[3] = '{a: 8'h12, b: 8'h34, op: 3'd5, exp_d: 8'h46, exp_c: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, op: 3'd7, exp_d: 8'hFE, exp_c: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'h00, op: 3'd3, exp_d: 8'h7F, exp_c: 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_res_data", res_data, 0);
    rst = 1'b0;
    #1 chk("release_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("first_edge_cmd_ready", cmd_ready, 1);

    // single commands, latency and carry
    for (int i = 0; i < 6; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // backpressure: 10 commands with consumer stalled
    sent = 0; got = 0;
    for (int k = 0; k < 15; k++) step(10, 1'b0);
    chk("stall_sent", sent, 8);
    chk("stall_cmd_ready", cmd_ready, 0);
    chk("stall_last_issued", alu_a, 4);
    chk("stall_res_valid", res_valid, 1);
    chk("stall_head", res_data, 8'h01);

    // full cmd FIFO: pop frees credit, issue happens next cycle, ready only after it
    chk("full_ready_c0", cmd_ready, 0);
    step(10, 1'b1);
    chk("full_ready_issue_cycle", cmd_ready, 0);
    step(10, 1'b1);
    chk("full_ready_after_issue", cmd_ready, 1);
    chk("full_issued_5", alu_a, 5);
    for (int k = 0; k < 40 && got < 10; k++) step(10, 1'b1);
    chk("drain_got", got, 10);
    chk("drain_sent", sent, 10);
    chk("drain_busy", busy, 0);

    // streaming throughput
    sent = 0; got = 0; first_v = -1; vcnt = 0;
    for (int c = 0; c < 24; c++) begin
      if (res_valid) begin
        vcnt++;
        if (first_v < 0) first_v = c;
      end
      step(20, 1'b1);
    end
    chk("stream_first_valid", first_v, 4);
    chk("stream_valid_cycles", vcnt, 20);
    chk("stream_got", got, 20);
    chk("stream_sent", sent, 20);
    chk("stream_idle", busy, 0);

    // reset with 2 in flight and 1 result queued
    cmd_valid = 1'b0; res_ready = 1'b0;
    chk("mid_rst_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_a = 8'h01; cmd_b = 8'h00; cmd_op = 3'd0;
    @(negedge clk); cmd_a = 8'h02;
    @(negedge clk); cmd_a = 8'h03;
    @(negedge clk); cmd_valid = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_res_valid", res_valid, 1);
    chk("pre_rst_alu_a", alu_a, 3);
    #1 rst = 1'b1;
    #1 chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_no_valid", res_valid, 0);
    chk("post_rst_busy", busy, 0);
    run_single('{a: 8'h21, b: 8'h22, op: 3'd4, exp_d: 8'h43, exp_c: 1'b0}, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
